// File: rtl/uart_rx_fifo.sv
// FWFT byte buffer behind a UART receiver: one entry per rising edge of done, visible the cycle after.
// Frames arriving while full (without a same-cycle pop) are dropped and flagged via sticky overflow.
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              uart_clk,
    input  logic              reset,
    input  logic [7:0]        uart_data,
    input  logic              uart_done,
    input  logic              uart_error,
    input  logic              rd_en,
    input  logic              clr_status,
    output logic [7:0]        rd_data,
    output logic              rd_error,
    output logic              rd_valid,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        err_count
);

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic              done_q;
    logic              wr;
    logic              rd;
    logic              push;
    logic              drop;

    assign wr   = uart_done & ~done_q;
    assign rd   = rd_en & rd_valid;
    assign push = wr & (~full | rd);
    assign drop = wr & full & ~rd;

    assign rd_valid = (count != '0);
    assign full     = (count == (ADDR_W+1)'(DEPTH));
    assign rd_data  = mem[rp][7:0];
    assign rd_error = mem[rp][8];

    // Storage is deliberately left out of reset.
    always_ff @(posedge uart_clk) begin
        if (push) begin
            mem[wp] <= {uart_error, uart_data};
        end
    end

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            done_q    <= 1'b1;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            done_q <= uart_done;
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (rd) begin
                rp <= rp + 1'b1;
            end
            if (push && !rd) begin
                count <= count + 1'b1;
            end else if (rd && !push) begin
                count <= count - 1'b1;
            end

            // A set/increment event in the same cycle as clr_status takes priority.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end

            if (wr && uart_error) begin
                if (clr_status) begin
                    err_count <= 8'd1;
                end else if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (clr_status) begin
                err_count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic            uart_clk = 1'b0;
    logic            reset;
    logic [7:0]      uart_data;
    logic            uart_done;
    logic            uart_error;
    logic            rd_en;
    logic            clr_status;
    logic [7:0]      rd_data;
    logic            rd_error;
    logic            rd_valid;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic [7:0]      err_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: stored frames, sticky overflow, saturating error count.
    logic [8:0] q[$];
    bit         m_ovf;
    int         m_err;
    bit         m_done_q;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .uart_clk   (uart_clk),
        .reset      (reset),
        .uart_data  (uart_data),
        .uart_done  (uart_done),
        .uart_error (uart_error),
        .rd_en      (rd_en),
        .clr_status (clr_status),
        .rd_data    (rd_data),
        .rd_error   (rd_error),
        .rd_valid   (rd_valid),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #5 uart_clk = ~uart_clk;

    // Drive one cycle of inputs, advance the model, then sit 1ns past the clock edge.
    task automatic tick(input bit d, input logic [7:0] data, input bit e, input bit r, input bit c);
        bit wr, pop, drop;
        uart_done  = d;
        uart_data  = data;
        uart_error = e;
        rd_en      = r;
        clr_status = c;
        wr   = d && !m_done_q;
        pop  = r && (q.size() > 0);
        drop = wr && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (wr && !drop) q.push_back({e, data});
        if (c) begin
            m_ovf = 1'b0;
            m_err = 0;
        end
        if (drop) m_ovf = 1'b1;
        if (wr && e && m_err < 255) m_err++;
        m_done_q = d;
        @(posedge uart_clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        uart_done = 1'b0; uart_data = 8'h00; uart_error = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
        #1;
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d valid=%b full=%b ovf=%b err=%0d, required all zero",
                     count, rd_valid, full, overflow, err_count);
        end
        q.delete(); m_ovf = 0; m_err = 0; m_done_q = 1;
        @(posedge uart_clk); #1;
        reset = 1'b0;
        tick(0, 8'h00, 0, 0, 0);
        tick(0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_single_frame;
        for (int i = 0; i < 4; i++) begin
            tick(1, 8'h6B, 0, 0, 0);
            vectors++;
            if (count !== 4'd1 || rd_valid !== 1'b1 || rd_data !== 8'h6B || rd_error !== 1'b0) begin
                miscompares++;
                $display("FAIL single_frame cyc%0d: count=%0d valid=%b data=%h err=%b, required 1 1 6b 0",
                         i, count, rd_valid, rd_data, rd_error);
            end
        end
        tick(0, 8'h00, 0, 0, 0);
        tick(0, 8'h00, 0, 1, 0);
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pop: count=%0d valid=%b, required 0 0", count, rd_valid);
        end
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 9; i++) begin
            tick(1, 8'(i), 0, 0, 0);
            if (i == 8) begin
                vectors++;
                if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fill_full: full=%b count=%0d ovf=%b, required 1 8 0", full, count, overflow);
                end
            end
            tick(0, 8'h00, 0, 0, 0);
        end
        vectors++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            miscompares++;
            $display("FAIL fill_overflow: ovf=%b count=%0d, required 1 8", overflow, count);
        end
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: valid=%b data=%h, required 1 %h", i, rd_valid, rd_data, 8'(i));
            end
            tick(0, 8'h00, 0, 1, 0);
        end
        vectors++;
        if (rd_valid !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_empty: valid=%b count=%0d, required 0 0", rd_valid, count);
        end
        tick(0, 8'h00, 0, 0, 1);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_overflow: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, 8'($urandom_range(0, 255)), 0, 0, 0);
            tick(0, 8'h00, 0, 0, 0);
        end
        tick(1, 8'hAA, 0, 1, 0);
        vectors++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            miscompares++;
            $display("FAIL full_push_pop: ovf=%b count=%0d, required 0 8", overflow, count);
        end
        tick(0, 8'h00, 0, 0, 0);
        while (q.size() > 1) begin
            vectors++;
            if (rd_data !== q[0][7:0]) begin
                miscompares++;
                $display("FAIL full_drain: data=%h, required %h", rd_data, q[0][7:0]);
            end
            tick(0, 8'h00, 0, 1, 0);
        end
        vectors++;
        if (rd_data !== 8'hAA || count !== 4'd1) begin
            miscompares++;
            $display("FAIL full_last: data=%h count=%0d, required aa 1", rd_data, count);
        end
        tick(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_errors;
        logic [3:0] exp_err = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick(1, 8'h35, exp_err[3-i], 0, 0);
            tick(0, 8'h00, 0, 0, 0);
        end
        vectors++;
        if (err_count !== 8'd3) begin
            miscompares++;
            $display("FAIL err_count3: got %0d, required 3", err_count);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rd_error !== exp_err[3-i] || rd_data !== 8'h35) begin
                miscompares++;
                $display("FAIL err_seq[%0d]: err=%b data=%h, required %b 35", i, rd_error, rd_data, exp_err[3-i]);
            end
            tick(0, 8'h00, 0, 1, 0);
        end
        for (int i = 0; i < 300; i++) begin
            tick(1, 8'($urandom_range(0, 255)), 1, 1, 0);
            tick(0, 8'h00, 0, 1, 0);
        end
        vectors++;
        if (err_count !== 8'd255 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL err_saturate: err=%0d ovf=%b, required 255 0", err_count, overflow);
        end
        tick(0, 8'h00, 0, 0, 1);
        vectors++;
        if (err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL err_clear: got %0d, required 0", err_count);
        end
        tick(1, 8'h11, 1, 0, 1);
        vectors++;
        if (err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL err_clear_race: got %0d, required 1", err_count);
        end
        tick(0, 8'h00, 0, 1, 1);
    endtask

    task automatic test_empty_wrap;
        tick(0, 8'h00, 0, 1, 0);
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_read: count=%0d valid=%b, required 0 0", count, rd_valid);
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            tick(1, b, 0, 0, 0);
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== b || count !== 4'd1) begin
                miscompares++;
                $display("FAIL wrap[%0d]: valid=%b data=%h count=%0d, required 1 %h 1", i, rd_valid, rd_data, count, b);
            end
            tick(0, 8'h00, 0, 1, 0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0));
            vectors++;
            if (count !== 4'(q.size()) || rd_valid !== (q.size() > 0) || full !== (q.size() == DEPTH) ||
                overflow !== m_ovf || err_count !== 8'(m_err) ||
                (q.size() > 0 && {rd_error, rd_data} !== q[0])) begin
                miscompares++;
                $display("FAIL random[%0d]: count=%0d ovf=%b err=%0d head=%h, required %0d %b %0d %h",
                         i, count, overflow, err_count, {rd_error, rd_data}, q.size(), m_ovf, m_err,
                         (q.size() > 0) ? q[0] : 9'h0);
            end
        end
    endtask

    task automatic test_reset_mid;
        tick(0, 8'h00, 0, 0, 1);
        while (q.size() > 0) tick(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 8'(8'h50 + i), 1, 0, 0);
            tick(0, 8'h00, 0, 0, 0);
        end
        uart_done = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid: count=%0d valid=%b full=%b ovf=%b err=%0d, required all zero",
                     count, rd_valid, full, overflow, err_count);
        end
        q.delete(); m_ovf = 0; m_err = 0; m_done_q = 1;
        @(posedge uart_clk); #1;
        reset = 1'b0;
        tick(1, 8'h77, 0, 0, 0);
        tick(1, 8'h77, 0, 0, 0);
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held_done: count=%0d valid=%b, required 0 0", count, rd_valid);
        end
        tick(0, 8'h00, 0, 0, 0);
        tick(1, 8'h9C, 0, 0, 0);
        vectors++;
        if (count !== 4'd1 || rd_data !== 8'h9C) begin
            miscompares++;
            $display("FAIL reset_next_edge: count=%0d data=%h, required 1 9c", count, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fill_overflow();
        test_full_push_pop();
        test_errors();
        test_empty_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
